// File: rtl/lc3_fetch_prefetch.sv
// LC3 fetch stage with prefetch queue.
// Issues instruction-memory reads from the PC, captures each response one cycle later
// into a small tagged FIFO, and presents the head entry to decode via valid/ready.
// A branch redirect flushes the FIFO, discards any response still in flight and
// inserts a one-cycle bubble before fetching resumes at the target.

module lc3_fetch_prefetch #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = 'h3000,
  parameter int                 DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable_fetch,
  input  logic                       br_taken,
  input  logic [ADDR_W-1:0]          taddr,
  output logic                       instrmem_rd,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_dout,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          npc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_npc,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic {
    FETCH  = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  logic [DATA_W-1:0]   instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]   tag_mem_q   [DEPTH];

  logic                issue;
  logic                push;
  logic                pop;
  logic [LVL_W-1:0]    occupancy;

  // Handshake decisions: when a read may issue, when a response lands, when decode takes one.
  // Occupancy counts the outstanding read so a returning response always has a free slot.
  always_comb begin
    occupancy = level_q + LVL_W'(inflight_q);
    issue     = (state_q == FETCH) && enable_fetch && !br_taken && !reset
                && (occupancy < DEPTH_L);
    push      = inflight_q && !br_taken && !reset;
    pop       = (level_q != '0) && out_ready;
  end

  // Next-state computation for the FSM, PC, in-flight tracking and queue pointers.
  always_comb begin
    state_d       = FETCH;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    level_d       = level_q;

    if (issue) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + ADDR_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    if (br_taken) begin
      state_d  = BUBBLE;
      pc_d     = taddr;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Control registers: FSM state, PC, in-flight tag and queue bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      level_q       <= level_d;
    end
  end

  // Queue storage: returning instruction and the PC it was fetched from.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_dout;
      tag_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  // Output drive: fetch-side address/PC and the head of the queue for decode.
  always_comb begin
    instrmem_rd = issue;
    imem_addr   = pc_q;
    pc          = pc_q;
    npc         = pc_q + ADDR_W'(1);
    out_valid   = (level_q != '0);
    out_instr   = instr_mem_q[rd_ptr_q];
    out_pc      = tag_mem_q[rd_ptr_q];
    out_npc     = tag_mem_q[rd_ptr_q] + ADDR_W'(1);
    level       = level_q;
  end

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
// Self-checking bench for lc3_fetch_prefetch.
// A queue-based reference model tracks what decode should see each cycle; directed
// sequences reach the interesting corners, then a long randomized run follows.

module tb_lc3_fetch_prefetch;

  localparam int          ADDR_W   = 16;
  localparam int          DATA_W   = 16;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h3000;

  logic                clock;
  logic                reset;
  logic                enable_fetch;
  logic                br_taken;
  logic [ADDR_W-1:0]   taddr;
  logic                instrmem_rd;
  logic [ADDR_W-1:0]   imem_addr;
  logic [DATA_W-1:0]   imem_dout;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   npc;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_instr;
  logic [ADDR_W-1:0]   out_pc;
  logic [ADDR_W-1:0]   out_npc;
  logic [$clog2(DEPTH):0] level;

  lc3_fetch_prefetch #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable_fetch(enable_fetch),
    .br_taken    (br_taken),
    .taddr       (taddr),
    .instrmem_rd (instrmem_rd),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .pc          (pc),
    .npc         (npc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_npc     (out_npc),
    .level       (level)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } entry_t;

  // Reference model state: what has been fetched and not yet consumed, in order.
  entry_t      mQueue[$];
  logic [15:0] mPc;
  logic [15:0] mInflightPc;
  bit          mInflight;
  bit          mBubble;

  // Memory emulation: remembers the read the DUT made last cycle.
  bit          pendingValid;
  logic [15:0] pendingAddr;

  int checks;
  int failures;

  bit          rndReset, rndEn, rndBr, rndReady;
  logic [15:0] rndTaddr;

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ 16'hC3A5;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare settled outputs
  // with the model, then advance the model across the coming rising edge.
  task automatic applyStimulus(input bit rst, input bit en, input bit br,
                               input logic [15:0] ta, input bit rdy, input bit doCheck);
    bit     expIssue;
    entry_t e;
    @(negedge clock);
    reset        = rst;
    enable_fetch = en;
    br_taken     = br;
    taddr        = ta;
    out_ready    = rdy;
    imem_dout    = pendingValid ? memWord(pendingAddr) : 16'($urandom);
    #1;

    expIssue = !rst && !mBubble && en && !br && ((mQueue.size() + int'(mInflight)) < DEPTH);

    if (doCheck) begin
      checkOutput("instrmem_rd", 32'(instrmem_rd), 32'(expIssue));
      if (expIssue) checkOutput("imem_addr", 32'(imem_addr), 32'(mPc));
      checkOutput("pc", 32'(pc), 32'(mPc));
      checkOutput("npc", 32'(npc), 32'(16'(mPc + 16'd1)));
      checkOutput("level", 32'(level), 32'(mQueue.size()));
      checkOutput("out_valid", 32'(out_valid), 32'(mQueue.size() != 0));
      if (mQueue.size() != 0) begin
        checkOutput("out_pc", 32'(out_pc), 32'(mQueue[0].pc));
        checkOutput("out_npc", 32'(out_npc), 32'(16'(mQueue[0].pc + 16'd1)));
        checkOutput("out_instr", 32'(out_instr), 32'(mQueue[0].instr));
      end
    end

    pendingValid = (instrmem_rd === 1'b1);
    pendingAddr  = imem_addr;

    if (rst) begin
      mPc       = RESET_PC;
      mQueue.delete();
      mInflight = 1'b0;
      mBubble   = 1'b0;
    end else begin
      if (rdy && mQueue.size() != 0) void'(mQueue.pop_front());
      if (mInflight && !br) begin
        e.pc    = mInflightPc;
        e.instr = memWord(mInflightPc);
        mQueue.push_back(e);
      end
      if (br) mQueue.delete();
      mInflightPc = mPc;
      mInflight   = expIssue;
      if (br)            mPc = ta;
      else if (expIssue) mPc = mPc + 16'd1;
      mBubble = br;
    end
  endtask

  // Directed corner sequences followed by randomized traffic, then the summary.
  initial begin
    checks       = 0;
    failures     = 0;
    pendingValid = 1'b0;
    pendingAddr  = '0;
    reset        = 1'b1;
    enable_fetch = 1'b0;
    br_taken     = 1'b0;
    taddr        = '0;
    out_ready    = 1'b0;
    imem_dout    = '0;
    mPc          = RESET_PC;
    mInflightPc  = '0;
    mInflight    = 1'b0;
    mBubble      = 1'b0;

    applyStimulus(1, 0, 0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1);

    // Streaming from reset with decode always ready.
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 16'h0, 1, 1);

    // Back-pressure until the queue fills, then release it.
    applyStimulus(1, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 16'h0, 1, 1);

    // Redirect while 0x3002 is in flight and two entries are queued.
    applyStimulus(1, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 16'h0, 0, 1);
    applyStimulus(0, 1, 1, 16'h3100, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 16'h0, 1, 1);

    // Redirect coinciding with a pop, then a back-to-back redirect during the bubble.
    applyStimulus(0, 1, 1, 16'h4000, 1, 1);
    applyStimulus(0, 1, 1, 16'h5000, 1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 16'h0, 1, 1);

    // Address wrap at the top of memory.
    applyStimulus(0, 1, 1, 16'hFFFF, 1, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 16'h0, 1, 1);

    // Fetch disabled: in-flight response still lands, queue keeps draining.
    applyStimulus(0, 0, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 16'h0, 1, 1);

    // Reset with three entries queued and a read outstanding.
    applyStimulus(1, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 16'h0, 0, 1);
    applyStimulus(1, 1, 0, 16'h0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 16'h0, 1, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rndReset = ($urandom_range(0, 299) == 0);
      rndEn    = ($urandom_range(0, 99) < 85);
      rndBr    = ($urandom_range(0, 99) < 7);
      rndReady = ($urandom_range(0, 99) < 65);
      case ($urandom_range(0, 3))
        0:       rndTaddr = 16'hFFFE;
        1:       rndTaddr = 16'hFFFF;
        default: rndTaddr = 16'($urandom);
      endcase
      applyStimulus(rndReset, rndEn, rndBr, rndTaddr, rndReady, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
